// File: rtl/coprocessor0.sv
// Coprocessor 0: MFC0/MTC0 register file, Count/Compare timer, exception state
// (EPC, Cause, Status.EXL) and the interrupt request to the pipeline controller.
module coprocessor0 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] PRID       = 32'h0001_8000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  reg_rw,
  input  logic [4:0]            reg_read_addr,
  output logic [DATA_WIDTH-1:0] reg_read,
  input  logic [4:0]            reg_write_addr,
  input  logic [DATA_WIDTH-1:0] reg_write,
  input  logic                  exc_req,
  input  logic [4:0]            exc_code,
  input  logic [DATA_WIDTH-1:0] exc_pc,
  input  logic                  exc_in_delay_slot,
  input  logic [DATA_WIDTH-1:0] exc_badvaddr,
  input  logic                  eret,
  input  logic [5:0]            hw_int,
  output logic [DATA_WIDTH-1:0] status,
  output logic [DATA_WIDTH-1:0] cause,
  output logic [DATA_WIDTH-1:0] epc,
  output logic                  int_req
);

  localparam int unsigned W = DATA_WIDTH;

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;

  logic [W-1:0] count_q;
  logic [W-1:0] compare_q;
  logic [W-1:0] epc_q;
  logic [W-1:0] badvaddr_q;

  // Status fields
  logic         cu0_q;
  logic [7:0]   im_q;
  logic         exl_q;
  logic         ie_q;

  // Cause fields
  logic         bd_q;
  logic         ti_q;
  logic [5:0]   ip_hw_q;
  logic [1:0]   ip_sw_q;
  logic [4:0]   exc_code_q;

  logic wr_count;
  logic wr_compare;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;
  logic timer_match;
  logic bad_addr_exc;

  assign wr_count     = reg_rw && (reg_write_addr == ADDR_COUNT);
  assign wr_compare   = reg_rw && (reg_write_addr == ADDR_COMPARE);
  assign wr_status    = reg_rw && (reg_write_addr == ADDR_STATUS);
  assign wr_cause     = reg_rw && (reg_write_addr == ADDR_CAUSE);
  assign wr_epc       = reg_rw && (reg_write_addr == ADDR_EPC);
  assign timer_match  = (count_q == compare_q) && (compare_q != '0);
  assign bad_addr_exc = (exc_code == 5'd4) || (exc_code == 5'd5);

  assign status = {3'b000, cu0_q, 12'h000, im_q, 6'b00_0000, exl_q, ie_q};
  assign cause  = {bd_q, ti_q, 14'h0000, ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q,
                   1'b0, exc_code_q, 2'b00};
  assign epc    = epc_q;

  assign int_req = ie_q && !exl_q && (|(im_q & cause[15:8]));

  // Count/Compare timer; a Compare write wins over a same-cycle match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
      ip_hw_q   <= '0;
    end else begin
      count_q <= wr_count ? reg_write : count_q + W'(1);
      ip_hw_q <= hw_int;
      if (wr_compare) begin
        compare_q <= reg_write;
        ti_q      <= 1'b0;
      end else if (timer_match) begin
        ti_q <= 1'b1;
      end
    end
  end

  // Status: exception entry beats ERET beats MTC0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cu0_q <= 1'b1;
      im_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
    end else if (exc_req) begin
      exl_q <= 1'b1;
    end else if (eret) begin
      exl_q <= 1'b0;
    end else if (wr_status) begin
      cu0_q <= reg_write[28];
      im_q  <= reg_write[15:8];
      exl_q <= reg_write[1];
      ie_q  <= reg_write[0];
    end
  end

  // Cause, EPC, BadVAddr; nested exceptions keep the original EPC and BD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bd_q       <= 1'b0;
      ip_sw_q    <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      if (exc_req) begin
        exc_code_q <= exc_code;
        if (!exl_q) begin
          bd_q  <= exc_in_delay_slot;
          epc_q <= exc_in_delay_slot ? exc_pc - W'(4) : exc_pc;
        end
        if (bad_addr_exc) begin
          badvaddr_q <= exc_badvaddr;
        end
      end else if (!eret) begin
        if (wr_cause) begin
          ip_sw_q <= reg_write[9:8];
        end
        if (wr_epc) begin
          epc_q <= reg_write;
        end
      end
    end
  end

  // Read port sees registered state only; the execution stage forwards
  always_comb begin
    reg_read = '0;
    unique case (reg_read_addr)
      ADDR_BADVADDR: reg_read = badvaddr_q;
      ADDR_COUNT:    reg_read = count_q;
      ADDR_COMPARE:  reg_read = compare_q;
      ADDR_STATUS:   reg_read = status;
      ADDR_CAUSE:    reg_read = cause;
      ADDR_EPC:      reg_read = epc_q;
      ADDR_PRID:     reg_read = PRID;
      default:       reg_read = '0;
    endcase
  end

endmodule

// File: doc/coprocessor0.md
Name: coprocessor0

Overview:
- Coprocessor 0 register file and exception-state holder. It is the responder side of the execution stage's MFC0/MTC0 interface.
- It serves combinational register reads, commits MTC0 writes at the clock edge, and runs the Count/Compare timer.
- It latches exception entry (EPC, Cause, Status.EXL) and clears EXL on ERET.
- It raises the interrupt request to the pipeline controller.

Parameters:
DATA_WIDTH, 32, register data width; only 32 is supported.
PRID, 32'h0001_8000, constant value returned for PRId (reg 15).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
reg_rw  input  1  1 = commit write this cycle (MTC0), 0 = no write
reg_read_addr  input  5  CP0 register number for the read port
reg_read  output  32  combinational read data
reg_write_addr  input  5  CP0 register number for the write port
reg_write  input  32  write data
exc_req  input  1  exception commit, single-cycle pulse from the memory stage
exc_code  input  5  ExcCode of the committing exception
exc_pc  input  32  PC of the faulting instruction
exc_in_delay_slot  input  1  faulting instruction is in a branch delay slot
exc_badvaddr  input  32  faulting address (AdEL/AdES only)
eret  input  1  ERET commit pulse
hw_int  input  6  external interrupt lines, level-sensitive
status  output  32  current Status register
cause  output  32  current Cause register
epc  output  32  current EPC register
int_req  output  1  pending enabled interrupt

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - Count, Compare, Cause, EPC, BadVAddr = 0.
  - Status = 32'h1000_0000 (CU0 set, IE = 0, EXL = 0).
  - int_req = 0.
- Implemented registers: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId.
- Reads:
  - Combinational from the registered state; no internal bypass.
  - A read of an address written in the same cycle returns the old value; the execution stage forwards.
  - Unimplemented addresses read 0.
- Writes (when reg_rw = 1):
  - BadVAddr and PRId are read-only; writes to them and to unimplemented addresses are ignored.
  - Status: write mask 32'h1000_FF03 (CU0, IM[15:8], EXL[1], IE[0]); all other bits read 0.
  - Cause: only IP[9:8] (software interrupts) are writable.
  - Count: loads the write data. It increments again from the following cycle, so a value written in cycle N reads back as that value in cycle N+1.
- Count:
  - Increments by 1 every clock when not being written.
  - Wraps from 32'hFFFF_FFFF to 0 with no flag.
- Timer interrupt:
  - When Count == Compare and Compare != 0, Cause.TI (bit 30) and Cause.IP[15] are set.
  - Both bits are sticky until a Compare write clears them.
  - A Compare write takes priority over a match in the same cycle.
- Hardware interrupts: Cause.IP[15:10] <= hw_int[5:0] every clock. IP[15] is ORed with TI.
- int_req is combinational from registered state: Status.IE & ~Status.EXL & |(Status.IM & Cause.IP).
- Exception entry (exc_req = 1), at the clock edge:
  - If Status.EXL == 0: EPC <= exc_in_delay_slot ? exc_pc - 4 : exc_pc; Cause.BD (bit 31) <= exc_in_delay_slot.
  - If EXL == 1: EPC and BD are unchanged (nested exception).
  - In both cases: Status.EXL <= 1 and Cause.ExcCode[6:2] <= exc_code.
  - BadVAddr <= exc_badvaddr only when exc_code is 4 (AdEL) or 5 (AdES).
- ERET (eret = 1): Status.EXL <= 0; no other state changes.
- Same-cycle priority:
  - exc_req over eret over MTC0 for Status, Cause and EPC.
  - A lower-priority MTC0 to those registers is dropped entirely.
  - MTC0 to Count or Compare still commits alongside exc_req or eret.
- Reset asserted mid-operation: all state returns to its reset value immediately (asynchronous); Count restarts from 0 after rst_n deasserts.

Test Plan:
- Reset, then idle 10 cycles: reg_read at addr 9 = 10 (±0 at the sampled edge); addr 12 = 32'h1000_0000; addr 15 = 32'h0001_8000; addr 3 = 0.
- MTC0 Count = 32'hFFFF_FFFE, then idle 2 cycles: Count reads FFFF_FFFF, then 0 (wrap); no other state changes.
- MTC0 Compare = 20, Status = 32'h0000_8001, Count = 15; after 5 cycles: Cause bit 30 and bit 15 set, int_req = 1. MTC0 Compare = 100: TI clears and int_req = 0 next cycle.
- exc_req with exc_code = 5, exc_pc = 32'h0000_1004, delay slot = 1, badvaddr = 32'h0000_0003: EPC = 32'h0000_1000, BD = 1, ExcCode = 5, EXL = 1, BadVAddr = 3, int_req forced 0.
- While EXL = 1, a second exc_req with pc = 32'h2000 and code 8: EPC unchanged, ExcCode = 8. Then eret: EXL = 0. Then exc_req and eret in the same cycle: EXL = 1.
- Same cycle as exc_req, MTC0 Status = 0 and MTC0 Compare = 7: Status keeps EXL = 1, Compare = 7. Assert rst_n = 0 mid-count: Count reads 0 within the same cycle.
